// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register controller: FSM state encoding
// and the default register bank depth.
package i2c_pkg;

  localparam int NUM_REGS_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PTR,
    ST_WRITE,
    ST_READ
  } state_e;

endpackage

// File: rtl/i2c_edge_pulse.sv
// Registered edge detector: one-cycle rise/fall pulses, one cycle after the
// input transition is sampled.
module i2c_edge_pulse
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
      rise_q <= sig_i & ~prev_q;
      fall_q <= ~sig_i & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2c_reg_ctrl.sv
// I2C slave register bank controller: pointer byte then auto-incrementing
// register writes, or auto-incrementing reads after a repeated START.
module i2c_reg_ctrl
  import i2c_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int RO_REG   = NUM_REGS - 1,
  parameter int PTR_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inframe,
  input  logic             sr_start,
  input  logic             addr_match,
  input  logic             rw_bit,
  input  logic [7:0]       rx_data,
  input  logic             send_rx,
  input  logic             get_tx,
  output logic [7:0]       tx_data,
  input  logic [7:0]       status_in,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_rdata,
  output logic             wr_pulse,
  output logic [PTR_W-1:0] wr_idx,
  output logic [7:0]       wr_val,
  output logic [PTR_W-1:0] ptr,
  output state_e           state_o
);

  localparam logic [PTR_W-1:0] RO_IDX = PTR_W'(RO_REG);

  logic inframe_rise, inframe_fall, sr_rise, rx_ev, tx_ev;
  logic sr_fall, rx_fall, tx_fall;
  logic frame_start, frame_end;
  logic unused_falls;

  state_e           state_q;
  logic [PTR_W-1:0] ptr_q;
  logic [7:0]       tx_q;
  logic             wr_pulse_q;
  logic [PTR_W-1:0] wr_idx_q;
  logic [7:0]       wr_val_q;
  logic             wait_idle_q;
  logic [7:0]       regs_q [NUM_REGS];
  logic [7:0]       rd_byte;

  i2c_edge_pulse u_inframe (.clk(clk), .rst(rst), .sig_i(inframe),  .rise_o(inframe_rise), .fall_o(inframe_fall));
  i2c_edge_pulse u_sr      (.clk(clk), .rst(rst), .sig_i(sr_start), .rise_o(sr_rise),      .fall_o(sr_fall));
  i2c_edge_pulse u_rx      (.clk(clk), .rst(rst), .sig_i(send_rx),  .rise_o(rx_ev),        .fall_o(rx_fall));
  i2c_edge_pulse u_tx      (.clk(clk), .rst(rst), .sig_i(get_tx),   .rise_o(tx_ev),        .fall_o(tx_fall));

  assign unused_falls = &{1'b0, sr_fall, rx_fall, tx_fall};

  // After a reset inside a frame, START pulses are ignored until the bus has
  // been seen idle, so the block only resumes on a genuine new frame.
  assign frame_start = (inframe_rise | sr_rise) & ~wait_idle_q;
  assign frame_end   = inframe_fall;

  assign rd_byte = (ptr_q == RO_IDX) ? status_in : regs_q[ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      tx_q        <= 8'hFF;
      wr_pulse_q  <= 1'b0;
      wr_idx_q    <= '0;
      wr_val_q    <= 8'h00;
      wait_idle_q <= 1'b1;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      wr_pulse_q <= 1'b0;
      if (!inframe) wait_idle_q <= 1'b0;
      case (state_q)
        ST_HDR: begin
          if (addr_match) begin
            if (!rw_bit) begin
              state_q <= ST_PTR;
            end else if (tx_ev) begin
              tx_q    <= rd_byte;
              ptr_q   <= ptr_q + 1'b1;
              state_q <= ST_READ;
            end
          end
        end
        ST_PTR: begin
          if (rx_ev && addr_match) begin
            ptr_q   <= rx_data[PTR_W-1:0];
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (rx_ev && addr_match) begin
            if (ptr_q != RO_IDX) begin
              regs_q[ptr_q] <= rx_data;
              wr_pulse_q    <= 1'b1;
              wr_idx_q      <= ptr_q;
              wr_val_q      <= rx_data;
            end
            ptr_q <= ptr_q + 1'b1;
          end
        end
        ST_READ: begin
          if (tx_ev && addr_match) begin
            tx_q  <= rd_byte;
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: ;
      endcase
      // Byte events above are serviced first; frame boundaries then win the state.
      if (frame_start) state_q <= ST_HDR;
      if (frame_end)   state_q <= ST_IDLE;
    end
  end

  assign host_rdata = (host_addr == RO_IDX) ? status_in : regs_q[host_addr];
  assign tx_data    = tx_q;
  assign wr_pulse   = wr_pulse_q;
  assign wr_idx     = wr_idx_q;
  assign wr_val     = wr_val_q;
  assign ptr        = ptr_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Self-checking bench for i2c_reg_ctrl: directed scenarios plus randomized
// frames checked against a register-bank reference model.
module tb_i2c_reg_ctrl;
  import i2c_pkg::*;

  localparam int NR = 16;
  localparam int PW = 4;
  localparam int RO = 15;

  logic          clk = 1'b0;
  logic          rst, inframe, sr_start, addr_match, rw_bit, send_rx, get_tx;
  logic [7:0]    rx_data, tx_data, status_in, host_rdata, wr_val;
  logic [PW-1:0] host_addr, wr_idx, ptr;
  logic          wr_pulse;
  state_e        state_o;

  always #5 clk = ~clk;

  i2c_reg_ctrl dut (
    .clk(clk), .rst(rst), .inframe(inframe), .sr_start(sr_start),
    .addr_match(addr_match), .rw_bit(rw_bit), .rx_data(rx_data),
    .send_rx(send_rx), .get_tx(get_tx), .tx_data(tx_data),
    .status_in(status_in), .host_addr(host_addr), .host_rdata(host_rdata),
    .wr_pulse(wr_pulse), .wr_idx(wr_idx), .wr_val(wr_val), .ptr(ptr),
    .state_o(state_o)
  );

  // Reference model: register array, pointer, last transmitted byte, write log.
  logic [7:0]  m_regs [NR];
  int          m_ptr;
  logic [7:0]  m_tx;
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  always @(negedge clk) if (wr_pulse === 1'b1) got_q.push_back({wr_idx, wr_val});

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    m_tx  = 8'hFF;
    exp_q.delete();
    got_q.delete();
  endfunction

  function automatic void m_load_ptr(input logic [7:0] b);
    m_ptr = int'(b) % NR;
  endfunction

  function automatic void m_write(input logic [7:0] b);
    if (m_ptr != RO) begin
      m_regs[m_ptr] = b;
      exp_q.push_back({4'(m_ptr), b});
    end
    m_ptr = (m_ptr + 1) % NR;
  endfunction

  function automatic void m_read();
    m_tx  = (m_ptr == RO) ? status_in : m_regs[m_ptr];
    m_ptr = (m_ptr + 1) % NR;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    m_reset();
  endtask

  task automatic frame_begin(input logic m, input logic rw);
    addr_match = m;
    rw_bit     = rw;
    inframe    = 1'b1;
    tick(4);
  endtask

  task automatic frame_stop();
    inframe = 1'b0;
    tick(4);
  endtask

  task automatic rep_start(input logic rw);
    rw_bit   = rw;
    sr_start = 1'b1;
    tick(2);
    sr_start = 1'b0;
    tick(3);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_data = b;
    send_rx = 1'b1;
    tick(hold);
    send_rx = 1'b0;
    tick(3);
  endtask

  task automatic get_byte();
    get_tx = 1'b1;
    tick(2);
    get_tx = 1'b0;
    tick(3);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    status_in = 8'h5A;
    do_reset();
    n_checks++; if (state_o !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", state_o, ST_IDLE); else n_pass++;
    n_checks++; if (ptr !== 4'd0) $display("FAIL reset_ptr: got %0d want 0", ptr); else n_pass++;
    n_checks++; if (tx_data !== 8'hFF) $display("FAIL reset_tx: got %h want ff", tx_data); else n_pass++;
    n_checks++; if (wr_pulse !== 1'b0) $display("FAIL reset_wr_pulse: got %b want 0", wr_pulse); else n_pass++;
    n_checks++; if (wr_idx !== 4'd0 || wr_val !== 8'h00) $display("FAIL reset_wr_fields: got %0d/%h want 0/00", wr_idx, wr_val); else n_pass++;
    for (int i = 0; i < NR; i++) begin
      host_addr = 4'(i);
      #1;
      n_checks++;
      if (host_rdata !== ((i == RO) ? status_in : 8'h00))
        $display("FAIL reset_reg%0d: got %h want %h", i, host_rdata, (i == RO) ? status_in : 8'h00);
      else n_pass++;
    end
  endtask

  task automatic test_write_frame();
    frame_begin(1'b1, 1'b0);
    send_byte(8'h03, 2); m_load_ptr(8'h03);
    send_byte(8'hA5, 2); m_write(8'hA5);
    send_byte(8'h5A, 2); m_write(8'h5A);
    frame_stop();
    host_addr = 4'd3; #1;
    n_checks++; if (host_rdata !== 8'hA5) $display("FAIL write_reg3: got %h want a5", host_rdata); else n_pass++;
    host_addr = 4'd4; #1;
    n_checks++; if (host_rdata !== 8'h5A) $display("FAIL write_reg4: got %h want 5a", host_rdata); else n_pass++;
    n_checks++; if (ptr !== 4'd5) $display("FAIL write_ptr: got %0d want 5", ptr); else n_pass++;
    n_checks++; if (got_q.size() != 2) $display("FAIL write_pulses: got %0d want 2", got_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL write_log%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_read_frame();
    frame_begin(1'b1, 1'b0);
    send_byte(8'h03, 2); m_load_ptr(8'h03);
    rep_start(1'b1);
    get_byte(); m_read();
    n_checks++; if (tx_data !== 8'hA5 || tx_data !== m_tx) $display("FAIL read_byte0: got %h want a5", tx_data); else n_pass++;
    get_byte(); m_read();
    n_checks++; if (tx_data !== 8'h5A || tx_data !== m_tx) $display("FAIL read_byte1: got %h want 5a", tx_data); else n_pass++;
    tick(6);
    n_checks++; if (tx_data !== 8'h5A) $display("FAIL read_hold: got %h want 5a", tx_data); else n_pass++;
    n_checks++; if (ptr !== 4'd5) $display("FAIL read_ptr: got %0d want 5", ptr); else n_pass++;
    frame_stop();
    n_checks++; if (state_o !== ST_IDLE) $display("FAIL read_end_state: got %0d want %0d", state_o, ST_IDLE); else n_pass++;
    n_checks++; if (got_q.size() != 0) $display("FAIL read_no_pulse: got %0d want 0", got_q.size()); else n_pass++;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_wrap();
    frame_begin(1'b1, 1'b0);
    send_byte(8'h0E, 2); m_load_ptr(8'h0E);
    send_byte(8'h11, 2); m_write(8'h11);
    send_byte(8'h22, 2); m_write(8'h22);
    frame_stop();
    host_addr = 4'd14; #1;
    n_checks++; if (host_rdata !== 8'h11) $display("FAIL wrap_reg14: got %h want 11", host_rdata); else n_pass++;
    n_checks++; if (ptr !== 4'd0) $display("FAIL wrap_ptr: got %0d want 0", ptr); else n_pass++;
    n_checks++; if (got_q.size() != 1) $display("FAIL wrap_pulses: got %0d want 1", got_q.size()); else n_pass++;
    n_checks++;
    if (got_q.size() > 0 && got_q[0] !== 12'hE11) $display("FAIL wrap_log0: got %h want e11", got_q[0]);
    else if (got_q.size() == 0) $display("FAIL wrap_log0: got none want e11");
    else n_pass++;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_read_ro();
    status_in = 8'hC3;
    frame_begin(1'b1, 1'b0);
    send_byte(8'h0F, 2); m_load_ptr(8'h0F);
    rep_start(1'b1);
    get_byte(); m_read();
    frame_stop();
    n_checks++; if (tx_data !== 8'hC3) $display("FAIL ro_tx: got %h want c3", tx_data); else n_pass++;
    n_checks++; if (ptr !== 4'd0) $display("FAIL ro_ptr: got %0d want 0", ptr); else n_pass++;
  endtask

  task automatic test_no_match();
    frame_begin(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 2);
    get_byte();
    frame_stop();
    n_checks++; if (got_q.size() != 0) $display("FAIL nomatch_pulses: got %0d want 0", got_q.size()); else n_pass++;
    n_checks++; if (ptr !== 4'(m_ptr)) $display("FAIL nomatch_ptr: got %0d want %0d", ptr, m_ptr); else n_pass++;
    n_checks++; if (tx_data !== m_tx) $display("FAIL nomatch_tx: got %h want %h", tx_data, m_tx); else n_pass++;
    for (int i = 0; i < RO; i++) begin
      host_addr = 4'(i); #1;
      n_checks++;
      if (host_rdata !== m_regs[i]) $display("FAIL nomatch_reg%0d: got %h want %h", i, host_rdata, m_regs[i]); else n_pass++;
    end
    got_q.delete();
  endtask

  task automatic test_long_hold();
    frame_begin(1'b1, 1'b0);
    send_byte(8'h02, 2); m_load_ptr(8'h02);
    send_byte(8'h77, 5); m_write(8'h77);
    frame_stop();
    n_checks++; if (got_q.size() != 1) $display("FAIL hold_pulses: got %0d want 1", got_q.size()); else n_pass++;
    n_checks++;
    if (got_q.size() == 0 || got_q[0] !== 12'h277) $display("FAIL hold_log0: got %0d entries want 277", got_q.size()); else n_pass++;
    n_checks++; if (ptr !== 4'd3) $display("FAIL hold_ptr: got %0d want 3", ptr); else n_pass++;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid_write();
    frame_begin(1'b1, 1'b0);
    send_byte(8'h06, 2);
    send_byte(8'h99, 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    m_reset();
    n_checks++; if (state_o !== ST_IDLE) $display("FAIL rstmid_state: got %0d want %0d", state_o, ST_IDLE); else n_pass++;
    n_checks++; if (tx_data !== 8'hFF) $display("FAIL rstmid_tx: got %h want ff", tx_data); else n_pass++;
    n_checks++; if (ptr !== 4'd0) $display("FAIL rstmid_ptr: got %0d want 0", ptr); else n_pass++;
    host_addr = 4'd6; #1;
    n_checks++; if (host_rdata !== 8'h00) $display("FAIL rstmid_reg6: got %h want 00", host_rdata); else n_pass++;
    // Still inside the aborted frame: bytes and repeated STARTs must be ignored.
    rep_start(1'b0);
    send_byte(8'h44, 2);
    n_checks++; if (state_o !== ST_IDLE) $display("FAIL rstmid_stay_idle: got %0d want %0d", state_o, ST_IDLE); else n_pass++;
    n_checks++; if (got_q.size() != 0) $display("FAIL rstmid_no_write: got %0d want 0", got_q.size()); else n_pass++;
    frame_stop();
    frame_begin(1'b1, 1'b0);
    send_byte(8'h01, 2); m_load_ptr(8'h01);
    send_byte(8'h55, 2); m_write(8'h55);
    frame_stop();
    host_addr = 4'd1; #1;
    n_checks++; if (host_rdata !== 8'h55) $display("FAIL rstmid_resume_reg1: got %h want 55", host_rdata); else n_pass++;
    n_checks++; if (got_q.size() != 1) $display("FAIL rstmid_resume_pulses: got %0d want 1", got_q.size()); else n_pass++;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      automatic int         kind = $urandom_range(0, 2);
      automatic int         n    = $urandom_range(1, 4);
      automatic logic [7:0] p    = 8'($urandom);
      status_in = 8'($urandom);
      if (kind == 2) begin
        frame_begin(1'b0, 1'($urandom));
        for (int i = 0; i < n; i++) send_byte(8'($urandom), 2);
        frame_stop();
      end else begin
        frame_begin(1'b1, 1'b0);
        send_byte(p, 2); m_load_ptr(p);
        if (kind == 0) begin
          for (int i = 0; i < n; i++) begin
            automatic logic [7:0] b = 8'($urandom);
            send_byte(b, $urandom_range(1, 4)); m_write(b);
          end
        end else begin
          rep_start(1'b1);
          for (int i = 0; i < n; i++) begin
            get_byte(); m_read();
            n_checks++;
            if (tx_data !== m_tx) $display("FAIL rand_tx f%0d b%0d: got %h want %h", f, i, tx_data, m_tx); else n_pass++;
          end
        end
        frame_stop();
      end
      n_checks++; if (ptr !== 4'(m_ptr)) $display("FAIL rand_ptr f%0d: got %0d want %0d", f, ptr, m_ptr); else n_pass++;
      n_checks++;
      if (got_q.size() != exp_q.size()) $display("FAIL rand_wr_count f%0d: got %0d want %0d", f, got_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) $display("FAIL rand_wr f%0d e%0d: got %h want %h", f, i, got_q[i], exp_q[i]); else n_pass++;
      end
      exp_q.delete(); got_q.delete();
    end
    for (int i = 0; i < NR; i++) begin
      host_addr = 4'(i); #1;
      n_checks++;
      if (host_rdata !== ((i == RO) ? status_in : m_regs[i]))
        $display("FAIL rand_host_reg%0d: got %h want %h", i, host_rdata, (i == RO) ? status_in : m_regs[i]);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b0; inframe = 1'b0; sr_start = 1'b0; addr_match = 1'b0; rw_bit = 1'b0;
    send_rx = 1'b0; get_tx = 1'b0; rx_data = 8'h00; status_in = 8'h00; host_addr = '0;
    tick(2);
    test_reset();
    test_write_frame();
    test_read_frame();
    test_wrap();
    test_read_ro();
    test_no_match();
    test_long_hold();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
